// File: rtl/ysyx_22050612_regfile_sb_if.sv
// Write, read and scoreboard signal bundle for the NPC register file.
// master = pipeline side (decode/writeback); slave = register file.
interface ysyx_22050612_regfile_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NRPORTS    = 2
);
    logic                          wen0;
    logic [ADDR_WIDTH-1:0]         waddr0;
    logic [DATA_WIDTH-1:0]         wdata0;
    logic                          wen1;
    logic [ADDR_WIDTH-1:0]         waddr1;
    logic [DATA_WIDTH-1:0]         wdata1;
    logic [NRPORTS*ADDR_WIDTH-1:0] raddr;
    logic [NRPORTS*DATA_WIDTH-1:0] rdata;
    logic [NRPORTS-1:0]            rbusy;
    logic                          sb_set;
    logic [ADDR_WIDTH-1:0]         sb_addr;
    logic                          sb_flush;
    logic [2**ADDR_WIDTH-1:0]      busy_vec;

    modport master (
        output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, sb_set, sb_addr, sb_flush,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, sb_set, sb_addr, sb_flush,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/ysyx_22050612_regfile_sb.sv
// Multi-port register file with write-to-read bypass and a pending-write scoreboard.
// Optional RF_TRACE_EN: prints rf[0..4] and busy_vec every negedge (simulation only).
module ysyx_22050612_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NRPORTS    = 2,
    parameter int ZERO_REG   = 1
) (
    input logic                       clk,
    input logic                       rst_n,
    ysyx_22050612_regfile_sb_if.slave rf
);
    localparam int Depth  = 2 ** ADDR_WIDTH;
    localparam bit ZeroEn = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] rf_q [Depth];
    logic [Depth-1:0]      busy_q;
    logic [Depth-1:0]      busy_d;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return ZeroEn && (a == '0);
    endfunction

    // Port 1 is assigned last so it wins a same-index conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < Depth; k++) rf_q[k] <= '0;
        end else begin
            if (rf.wen0 && !is_zero(rf.waddr0)) rf_q[rf.waddr0] <= rf.wdata0;
            if (rf.wen1 && !is_zero(rf.waddr1)) rf_q[rf.waddr1] <= rf.wdata1;
        end
    end

    // Writeback clears, a new producer sets, flush trumps both.
    always_comb begin
        busy_d = busy_q;
        if (rf.wen0) busy_d[rf.waddr0] = 1'b0;
        if (rf.wen1) busy_d[rf.waddr1] = 1'b0;
        if (rf.sb_set) busy_d[rf.sb_addr] = 1'b1;
        if (rf.sb_flush) busy_d = '0;
        if (ZeroEn) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rf.busy_vec = busy_q;

    for (genvar i = 0; i < NRPORTS; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit0;
        logic                  hit1;
        logic [DATA_WIDTH-1:0] rd;

        assign ra   = rf.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit0 = rf.wen0 && (rf.waddr0 == ra);
        assign hit1 = rf.wen1 && (rf.waddr1 == ra);

        // Outputs are forced to zero while in reset so bypass data cannot leak.
        always_comb begin
            if (!rst_n || is_zero(ra)) rd = '0;
            else if (hit1)             rd = rf.wdata1;
            else if (hit0)             rd = rf.wdata0;
            else                       rd = rf_q[ra];
        end

        assign rf.rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rf.rbusy[i] = rst_n && !is_zero(ra) && busy_q[ra] && !(hit0 || hit1);
    end

`ifdef RF_TRACE_EN
    always @(negedge clk) begin
        if (rst_n) begin
            $display("rf: %0d, %0d, %0d, %0d, %0d busy=%h",
                     rf_q[0], rf_q[1], rf_q[2], rf_q[3], rf_q[4], busy_q);
        end
    end
`else
`endif
endmodule

// File: doc/ysyx_22050612_regfile_sb.md
Name: ysyx_22050612_regfile_sb

Overview:
Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the pipelined NPC core.
- Provides NRPORTS combinational read ports with write-to-read bypass.
- Provides two write ports: port 0 for ALU writeback, port 1 for LSU writeback.
- Register 0 is hardwired to zero.
- Decode uses the busy bits to stall on RAW hazards; flush clears them on redirect.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 64, register data width
NRPORTS, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = ordinary register

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
wen0  in  1  write enable, port 0
waddr0  in  ADDR_WIDTH  write index, port 0
wdata0  in  DATA_WIDTH  write data, port 0
wen1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_WIDTH  write index, port 1
wdata1  in  DATA_WIDTH  write data, port 1
raddr  in  NRPORTS*ADDR_WIDTH  read indices; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NRPORTS*DATA_WIDTH  read data, same packing
rbusy  out  NRPORTS  1 = register read on port i has a pending producer
sb_set  in  1  mark sb_addr busy (instruction issued with rd)
sb_addr  in  ADDR_WIDTH  register to mark busy
sb_flush  in  1  clear all busy bits (pipeline redirect)
busy_vec  out  2**ADDR_WIDTH  raw scoreboard state, for debug

Behaviour:
Reset:
- Async assert of rst_n sets all registers and all busy bits to 0 immediately.
- While rst_n is low: rdata = 0, rbusy = 0, busy_vec = 0.
- Writes, sb_set and sb_flush are ignored while rst_n is low.
- Reset asserted mid-operation discards any in-flight write. No partial update survives.

Write (posedge):
- If wenK and the target is not the zero register: rf[waddrK] <= wdataK.
- Both ports write the same index in one cycle: port 1 data is stored and port 0 is dropped.
- Different indices: both writes commit in the same cycle.

Read (combinational, zero latency):
- Priority for rdata[i]: (1) ZERO_REG and raddr[i]==0 -> 0; (2) wen1 and waddr1==raddr[i] -> wdata1; (3) wen0 and waddr0==raddr[i] -> wdata0; (4) rf[raddr[i]].
- The bypass means a same-cycle writer is visible to readers.

Scoreboard (posedge), evaluated in this order:
- (a) A write on either port to address A clears busy[A].
- (b) sb_set sets busy[sb_addr]. A set overrides a same-cycle clear of the same address, because the new producer supersedes the old one.
- (c) sb_flush forces every busy bit to 0. It overrides both (a) and (b).
- With ZERO_REG=1, busy[0] stays 0 permanently and sb_set to 0 has no effect.
- Setting an already-busy register leaves it busy. No counting: one outstanding producer per register.
- rbusy[i] = busy[raddr[i]] & ~(same-cycle write to raddr[i]). A register whose writeback arrives this cycle reads not-busy, and its data is bypassed.
- rbusy[i] is 0 for register 0 when ZERO_REG=1.
- busy_vec is the registered state only, without bypass.

Optional Feature:
Macro: RF_TRACE_EN
- Defined: on every negedge clk with rst_n high, $display prints rf[0]..rf[4] in decimal, comma-separated, followed by busy_vec in hex. Simulation only.
- Undefined: no display statements are compiled. The block is fully synthesizable and functionally identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after writing rf[3]=0x55 -> rdata for raddr=3 reads 0 at once; busy_vec=0; after release, rf[3] still reads 0.
- Write/read bypass: wen0=1, waddr0=5, wdata0=0x1234, raddr port0=5 in the same cycle -> rdata port0=0x1234 that cycle and after the edge.
- Port conflict: wen0 and wen1 both target index 7, with 0xAAAA and 0xBBBB -> rf[7]=0xBBBB.
- Zero register: write 0xFFFF to index 0 and sb_set with sb_addr=0 -> reads 0, rbusy=0, busy_vec[0]=0.
- Scoreboard: sb_set on x9 -> next cycle rbusy=1. In a later cycle, wen1 to x9 with sb_set on x9 together -> busy[9] stays 1 (set wins), and rbusy=0 only in that write cycle. Then sb_flush=1 -> busy_vec=0 next cycle.
- Multi-port: NRPORTS=3, raddr=(1,2,1) with rf[1]=10 and rf[2]=20 -> rdata=(10,20,10) and all rbusy=0.
